mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style FSM control unit for the multicycle MIPS datapath; successor of the single-cycle combinational decoder.
- Sequences each instruction over 3-5 states: shared ALU, shared instruction/data memory, IR/MDR/A/B/ALUOut registers held in the datapath.
- Supports variable-latency memory via a req/ready handshake with a timeout.
- Same ISA subset as the single-cycle decoder: R-type (ADD, SUB, AND, OR, SLT), LW, SW, BEQ, BNE, ADDI, SLTI, ORI, ANDI, J.

Parameters:
- OP_W, 6, opcode width.
- FUNCT_W, 6, funct width.
- ALU_CTRL_W, 3, alu_ctrl width; must be >= 3; codes are zero-extended.
- MEM_TIMEOUT, 255, max cycles waiting on mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode from IR; valid from DECODE onward.
- funct  in  FUNCT_W  funct from IR.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_read, mem_write  out  1  access type.
- iord  out  1  0=PC address, 1=ALUOut address.
- ir_write, pc_write, pc_write_cond, is_bne  out  1  PC/IR enables.
- reg_write, reg_dst, mem_to_reg, sign_ext  out  1  register-file path controls.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target.
- alu_ctrl  out  ALU_CTRL_W  AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- instr_done  out  1  1-cycle pulse when an instruction retires.
- mem_timeout  out  1  1-cycle pulse when an access is abandoned.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset: while rst=1, all outputs are 0 except sign_ext=1; state <= FETCH; timeout counter <= 0. Reset mid-instruction aborts it with no write issued in the reset cycle.
- Default output values per state: all enables 0, sign_ext=1, alu_ctrl=ADD.
- FETCH:
  - Drives mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; that cycle the FSM moves to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, ADD (branch target precomputed into ALUOut).
  - Next state: LW/SW -> MEM_ADDR; R -> R_EXEC; BEQ/BNE -> BRANCH; ADDI/SLTI/ORI/ANDI -> I_EXEC; J -> JUMP; other -> illegal handling.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next: LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: mem_req=1, mem_read=1, iord=1. Waits for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. -> FETCH.
- MEM_WR: mem_req=1, mem_write=1, iord=1. On mem_ready: instr_done=1, -> FETCH.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00; alu_ctrl from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT).
  - Next: R_WB. An unknown funct takes illegal handling.
- R_WB: reg_dst=1, reg_write=1, instr_done=1. -> FETCH.
- I_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - ADDI: ADD, sign_ext=1. SLTI: SLT, sign_ext=1. ORI: OR, sign_ext=0. ANDI: AND, sign_ext=0.
  - Next: I_WB.
- I_WB: reg_dst=0, reg_write=1, instr_done=1. Must keep the same sign_ext and alu_ctrl as I_EXEC. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, is_bne=(op==BNE), instr_done=1. -> FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. -> FETCH.
- Memory handshake:
  - mem_req holds steady until mem_ready; mem_ready while mem_req=0 is ignored.
  - The counter clears on entry to any memory state and increments each waiting cycle.
  - When count reaches MEM_TIMEOUT with no mem_ready: mem_timeout=1 for 1 cycle, no write enables, state -> FETCH (retries at the unchanged PC).
  - mem_ready arriving in the timeout cycle wins: the access completes.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode or funct enters TRAP. TRAP asserts output trap=1 and stays there, all enables 0, until rst.
- Undefined: an illegal opcode or funct is a NOP. DECODE/R_EXEC -> FETCH with instr_done=1; the trap port does not exist.

Decomposition:
- Shared header (alongside the existing control/ALU define headers) holds: opcode/funct codes, ALU codes, the state encoding (4-bit localparams), and the alu_src_b/pc_source encodings.
- Natural sub-module: mips_alu_decode, a combinational op/funct -> alu_ctrl, sign_ext, illegal decoder. Used by both the R_EXEC and I_EXEC paths.

Test Plan:
- R-type ADD (op=000000, funct=100000), mem_ready=1 in FETCH: states FETCH, DECODE, R_EXEC, R_WB; alu_ctrl=010 in R_EXEC; reg_dst=1 and reg_write=1 in R_WB; instr_done pulses in cycle 4.
- LW with 3-cycle memory latency: MEM_RD holds mem_req=1, iord=1 for 3 cycles; MEM_WB asserts mem_to_reg=1, reg_write=1; total 5+2+2 wait cycles.
- BNE (000101) -> BRANCH with pc_write_cond=1, is_bne=1, alu_ctrl=110, pc_source=01. ORI (001101) -> I_EXEC/I_WB with sign_ext=0, alu_ctrl=001.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: mem_timeout pulses once after 4 waiting cycles; ir_write and pc_write never assert; FSM returns to FETCH.
- rst asserted during MEM_WR with mem_ready=1 the same cycle: mem_write=0 and state FETCH next cycle. Op=111111 -> trap=1 (macro defined) or instr_done and return to FETCH (undefined).

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALU codes, datapath mux selects and the FSM state encoding.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // States that hold a memory request open and run the timeout counter.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational op/funct decoder: ALU operation, immediate extension mode and
// an illegal flag for unknown opcodes or unknown R-type funct codes.
module mips_alu_decode
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3
) (
  input  logic [OP_W-1:0]       op,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  sign_ext,
  output logic                  illegal
);

  logic [2:0] alu_code;

  always_comb begin
    alu_code = ALU_ADD;
    sign_ext = 1'b1;
    illegal  = 1'b0;
    case (op)
      OP_W'(OP_RTYPE): begin
        case (funct)
          FUNCT_W'(FUNCT_ADD): alu_code = ALU_ADD;
          FUNCT_W'(FUNCT_SUB): alu_code = ALU_SUB;
          FUNCT_W'(FUNCT_AND): alu_code = ALU_AND;
          FUNCT_W'(FUNCT_OR):  alu_code = ALU_OR;
          FUNCT_W'(FUNCT_SLT): alu_code = ALU_SLT;
          default:             illegal  = 1'b1;
        endcase
      end
      OP_W'(OP_ADDI): alu_code = ALU_ADD;
      OP_W'(OP_SLTI): alu_code = ALU_SLT;
      OP_W'(OP_ORI): begin
        alu_code = ALU_OR;
        sign_ext = 1'b0;
      end
      OP_W'(OP_ANDI): begin
        alu_code = ALU_AND;
        sign_ext = 1'b0;
      end
      OP_W'(OP_BEQ), OP_W'(OP_BNE): alu_code = ALU_SUB;
      OP_W'(OP_LW), OP_W'(OP_SW), OP_W'(OP_J): alu_code = ALU_ADD;
      default: illegal = 1'b1;
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(alu_code);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multicycle MIPS control FSM with req/ready memory handshake and
// timeout. Optional macro MIPS_CTRL_ILLEGAL_TRAP_EN: illegal ops enter a sticky TRAP.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       op,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  is_bne,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  sign_ext,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_source,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  instr_done,
  output logic                  mem_timeout,
  output logic [3:0]            state_o
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  , output logic                trap
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [ALU_CTRL_W-1:0] dec_alu_ctrl;
  logic               dec_sign_ext;
  logic               dec_illegal;
  logic               timeout_hit;

  mips_alu_decode #(
    .OP_W       (OP_W),
    .FUNCT_W    (FUNCT_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decode (
    .op       (op),
    .funct    (funct),
    .alu_ctrl (dec_alu_ctrl),
    .sign_ext (dec_sign_ext),
    .illegal  (dec_illegal)
  );

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_reg == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = '0;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    is_bne        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    sign_ext      = 1'b1;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_ctrl      = '0;
    instr_done    = 1'b0;
    mem_timeout   = 1'b0;
    state_o       = '0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    trap          = 1'b0;
`endif
    // Reset masks every output so an aborted instruction issues no write.
    if (!rst) begin
      alu_ctrl = ALU_CTRL_W'(ALU_ADD);
      state_o  = state_reg;
      case (state_reg)
        S_FETCH: begin
          mem_req   = 1'b1;
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          case (op)
            OP_W'(OP_LW), OP_W'(OP_SW):     state_next = S_MEM_ADDR;
            OP_W'(OP_RTYPE):                state_next = S_R_EXEC;
            OP_W'(OP_BEQ), OP_W'(OP_BNE):   state_next = S_BRANCH;
            OP_W'(OP_ADDI), OP_W'(OP_SLTI),
            OP_W'(OP_ORI), OP_W'(OP_ANDI):  state_next = S_I_EXEC;
            OP_W'(OP_J):                    state_next = S_JUMP;
            default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
              state_next = S_TRAP;
`else
              instr_done = 1'b1;
              state_next = S_FETCH;
`endif
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          state_next = (op == OP_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_next = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_ctrl  = dec_alu_ctrl;
          if (dec_illegal) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            instr_done = 1'b1;
            state_next = S_FETCH;
`endif
          end else begin
            state_next = S_R_WB;
          end
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_I_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_ctrl   = dec_alu_ctrl;
          sign_ext   = dec_sign_ext;
          state_next = S_I_WB;
        end
        S_I_WB: begin
          // IR still holds the opcode, so the immediate path stays stable.
          alu_ctrl   = dec_alu_ctrl;
          sign_ext   = dec_sign_ext;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ctrl      = ALU_CTRL_W'(ALU_SUB);
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          is_bne        = (op == OP_W'(OP_BNE));
          instr_done    = 1'b1;
          state_next    = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        S_TRAP: trap = 1'b1;
`endif
        default: state_next = S_FETCH;
      endcase

      // A completed or abandoned access leaves cnt_next at zero for the next entry.
      if (is_mem_state(state_reg) && !mem_ready) begin
        if (timeout_hit) begin
          mem_timeout = 1'b1;
          state_next  = S_FETCH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (MEM_TIMEOUT=4);
// inputs change and outputs are sampled just after the falling edge.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic       pc_write_cond, is_bne, reg_write, reg_dst, mem_to_reg, sign_ext;
  logic       alu_src_a, instr_done, mem_timeout;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic       trap;
`endif

  int          tests  = 0;
  int          failed = 0;
  int          ncyc;
  logic [31:0] got, exp;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(
    .OP_W(6), .FUNCT_W(6), .ALU_CTRL_W(3), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .is_bne(is_bne), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .sign_ext(sign_ext), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    , .trap(trap)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = OP_SW; funct = 6'd0;
    repeat (2) @(negedge clk);
    #1;
    got = 32'({state_o, mem_req, mem_write, ir_write, pc_write, sign_ext, alu_ctrl, alu_src_b, instr_done});
    exp = 32'({4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    got = 32'({state_o, mem_req, mem_read, iord, alu_src_a, alu_src_b, alu_ctrl, ir_write});
    exp = 32'({S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
    $display("[TB] txn reset");
  endtask

  task automatic test_rtype_add();
    @(negedge clk); op = OP_RTYPE; funct = FUNCT_ADD; mem_ready = 1'b1; #1;
    got = 32'({state_o, ir_write, pc_write, mem_req});
    exp = 32'({S_FETCH, 1'b1, 1'b1, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL rtype_fetch got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, alu_src_a, alu_src_b, alu_ctrl, ir_write});
    exp = 32'({S_DECODE, 1'b0, 2'b11, 3'b010, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL rtype_decode got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, alu_src_a, alu_src_b, alu_ctrl, reg_write, instr_done});
    exp = 32'({S_R_EXEC, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL rtype_exec got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, reg_dst, reg_write, mem_to_reg, instr_done});
    exp = 32'({S_R_WB, 1'b1, 1'b1, 1'b0, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL rtype_wb got=%h exp=%h", got, exp); end
    $display("[TB] txn rtype add");
  endtask

  task automatic test_rtype_funct();
    logic [5:0] fn   [4] = '{FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
    logic [2:0] code [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); op = OP_RTYPE; funct = fn[i]; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk); #1;
      got = 32'({state_o, alu_ctrl});
      exp = 32'({S_R_EXEC, code[i]}); tests++;
      if (got !== exp) begin failed++; $display("FAIL rtype_funct_%0d got=%h exp=%h", i, got, exp); end
      @(negedge clk);
      $display("[TB] txn rtype funct=%b", fn[i]);
    end
  endtask

  task automatic test_lw_latency();
    ncyc = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); op = OP_LW; mem_ready = 1'b0; #1; ncyc++;
      got = 32'({state_o, mem_req, mem_read, iord, ir_write, pc_write});
      exp = 32'({S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}); tests++;
      if (got !== exp) begin failed++; $display("FAIL lw_fetch_wait got=%h exp=%h", got, exp); end
    end
    @(negedge clk); mem_ready = 1'b1; #1; ncyc++;
    got = 32'({state_o, ir_write, pc_write});
    exp = 32'({S_FETCH, 1'b1, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL lw_fetch_done got=%h exp=%h", got, exp); end
    @(negedge clk); mem_ready = 1'b0; #1; ncyc++;
    @(negedge clk); #1; ncyc++;
    got = 32'({state_o, alu_src_a, alu_src_b, alu_ctrl});
    exp = 32'({S_MEM_ADDR, 1'b1, 2'b10, 3'b010}); tests++;
    if (got !== exp) begin failed++; $display("FAIL lw_mem_addr got=%h exp=%h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = (i == 2); #1; ncyc++;
      got = 32'({state_o, mem_req, mem_read, iord, mem_write});
      exp = 32'({S_MEM_RD, 1'b1, 1'b1, 1'b1, 1'b0}); tests++;
      if (got !== exp) begin failed++; $display("FAIL lw_mem_rd_%0d got=%h exp=%h", i, got, exp); end
    end
    @(negedge clk); mem_ready = 1'b0; #1; ncyc++;
    got = 32'({state_o, reg_write, mem_to_reg, reg_dst, instr_done});
    exp = 32'({S_MEM_WB, 1'b1, 1'b1, 1'b0, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL lw_mem_wb got=%h exp=%h", got, exp); end
    tests++;
    if (ncyc != 9) begin failed++; $display("FAIL lw_cycles got=%0d exp=9", ncyc); end
    $display("[TB] txn lw latency=3");
  endtask

  task automatic test_branch(input logic [5:0] bop, input logic exp_bne);
    @(negedge clk); op = bop; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    got = 32'({state_o, pc_write_cond, is_bne, alu_ctrl, pc_source, alu_src_a, alu_src_b, pc_write, instr_done});
    exp = 32'({S_BRANCH, 1'b1, exp_bne, 3'b110, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL branch_op%b got=%h exp=%h", bop, got, exp); end
    $display("[TB] txn branch op=%b", bop);
  endtask

  task automatic test_itype(input logic [5:0] iop, input logic se, input logic [2:0] code);
    @(negedge clk); op = iop; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    got = 32'({state_o, alu_src_a, alu_src_b, sign_ext, alu_ctrl, reg_write});
    exp = 32'({S_I_EXEC, 1'b1, 2'b10, se, code, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL iexec_op%b got=%h exp=%h", iop, got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, reg_write, reg_dst, sign_ext, alu_ctrl, instr_done});
    exp = 32'({S_I_WB, 1'b1, 1'b0, se, code, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL iwb_op%b got=%h exp=%h", iop, got, exp); end
    $display("[TB] txn itype op=%b", iop);
  endtask

  task automatic test_timeout_and_jump();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); op = OP_J; mem_ready = 1'b0; #1;
      got = 32'({state_o, mem_timeout, ir_write, pc_write, mem_req});
      exp = 32'({S_FETCH, 1'b0, 1'b0, 1'b0, 1'b1}); tests++;
      if (got !== exp) begin failed++; $display("FAIL timeout_wait_%0d got=%h exp=%h", i, got, exp); end
    end
    @(negedge clk); #1;
    got = 32'({state_o, mem_timeout, ir_write, pc_write, mem_req});
    exp = 32'({S_FETCH, 1'b1, 1'b0, 1'b0, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL timeout_pulse got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, mem_timeout, ir_write, pc_write, mem_req});
    exp = 32'({S_FETCH, 1'b0, 1'b0, 1'b0, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL timeout_retry got=%h exp=%h", got, exp); end
    repeat (3) @(negedge clk);
    @(negedge clk); mem_ready = 1'b1; #1;
    got = 32'({state_o, mem_timeout, ir_write, pc_write});
    exp = 32'({S_FETCH, 1'b0, 1'b1, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL timeout_ready_wins got=%h exp=%h", got, exp); end
    @(negedge clk);
    @(negedge clk); #1;
    got = 32'({state_o, pc_write, pc_source, instr_done, pc_write_cond});
    exp = 32'({S_JUMP, 1'b1, 2'b10, 1'b1, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL jump got=%h exp=%h", got, exp); end
    $display("[TB] txn timeout then jump");
  endtask

  task automatic test_sw_and_reset_mid();
    @(negedge clk); op = OP_SW; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    got = 32'({state_o, mem_req, mem_write, mem_read, iord, instr_done});
    exp = 32'({S_MEM_WR, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL sw_wait got=%h exp=%h", got, exp); end
    @(negedge clk); mem_ready = 1'b1; #1;
    got = 32'({state_o, mem_write, instr_done});
    exp = 32'({S_MEM_WR, 1'b1, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL sw_done got=%h exp=%h", got, exp); end
    $display("[TB] txn sw");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    got = 32'({state_o});
    exp = 32'({S_MEM_ADDR}); tests++;
    if (got !== exp) begin failed++; $display("FAIL sw2_mem_addr got=%h exp=%h", got, exp); end
    @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
    got = 32'({state_o, mem_req, mem_write, instr_done, sign_ext});
    exp = 32'({4'd0, 1'b0, 1'b0, 1'b0, 1'b1}); tests++;
    if (got !== exp) begin failed++; $display("FAIL reset_mid_write got=%h exp=%h", got, exp); end
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    got = 32'({state_o, mem_req, mem_read, mem_write});
    exp = 32'({S_FETCH, 1'b1, 1'b1, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL reset_mid_after got=%h exp=%h", got, exp); end
    $display("[TB] txn sw aborted by reset");
  endtask

  task automatic test_illegal();
    @(negedge clk); op = OP_RTYPE; funct = 6'b111111; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    got = 32'({state_o, instr_done, reg_write});
    exp = 32'({S_R_EXEC, 1'b0, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL bad_funct_exec got=%h exp=%h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      got = 32'({state_o, trap, mem_req, pc_write, reg_write, instr_done});
      exp = 32'({S_TRAP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}); tests++;
      if (got !== exp) begin failed++; $display("FAIL bad_funct_trap_%0d got=%h exp=%h", i, got, exp); end
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; op = 6'b111111; #1;
    got = 32'({state_o, trap});
    exp = 32'({S_FETCH, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL trap_cleared got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, instr_done});
    exp = 32'({S_DECODE, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL bad_op_decode got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, trap, instr_done});
    exp = 32'({S_TRAP, 1'b1, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL bad_op_trap got=%h exp=%h", got, exp); end
`else
    got = 32'({state_o, instr_done, reg_write});
    exp = 32'({S_R_EXEC, 1'b1, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL bad_funct_nop got=%h exp=%h", got, exp); end
    @(negedge clk); op = 6'b111111; #1;
    got = 32'({state_o});
    exp = 32'({S_FETCH}); tests++;
    if (got !== exp) begin failed++; $display("FAIL bad_funct_return got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, instr_done, reg_write, pc_write});
    exp = 32'({S_DECODE, 1'b1, 1'b0, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL bad_op_nop got=%h exp=%h", got, exp); end
    @(negedge clk); #1;
    got = 32'({state_o, instr_done});
    exp = 32'({S_FETCH, 1'b0}); tests++;
    if (got !== exp) begin failed++; $display("FAIL bad_op_return got=%h exp=%h", got, exp); end
`endif
    $display("[TB] txn illegal op/funct");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype_add();
    test_rtype_funct();
    test_lw_latency();
    test_branch(OP_BNE, 1'b1);
    test_branch(OP_BEQ, 1'b0);
    test_itype(OP_ORI,  1'b0, 3'b001);
    test_itype(OP_ADDI, 1'b1, 3'b010);
    test_itype(OP_SLTI, 1'b1, 3'b111);
    test_itype(OP_ANDI, 1'b0, 3'b000);
    test_timeout_and_jump();
    test_sw_and_reset_mid();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
